osd_init_seq_chunked: RTL and testbench
=======================================

// Module: osd_init_seq_chunked
// PURPOSE
//  OSD bring-up sequencer, 2nd gen: optional rectangular VRAM fill, then streams
//  osd_cmd_t beats into the batch enqueuer. Streams longer than NUM_CMDS_MAX are
//  split into chunks of up to NUM_CMDS_MAX commands, one be_start per chunk.
//  Adds VRAM backpressure, abort, be_done watchdog and error reporting.
//  Sits between the boot/host stream source and the OSD batch enqueuer + char VRAM.
// PARAMETERS
//  COLS          40      text columns
//  ROWS          20      text rows
//  NUM_CMDS_MAX  64      enqueuer buffer depth (cmds per chunk)
//  ADDR_W        16      VRAM address width
//  VRAM_BASE     0       VRAM address of cell (0,0)
//  WD_CYCLES     65535   max cycles in S_WAIT before TIMEOUT; 0 disables
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset: asynchronous, active-high
//  init_start     in   1        level; rising request starts sequence
//  init_abort     in   1        abort request
//  init_busy      out  1        sequence running
//  init_done      out  1        completed OK (held)
//  init_err       out  2        osd_init_err_t: NONE/ABORT/TIMEOUT (held)
//  chunk_count    out  8        be_start pulses issued this run (saturates at 255)
//  clear_enable   in   1        do fill before loading
//  clear_char     in   8        fill character
//  clear_x0/y0    in   X_W/Y_W  rectangle origin (sampled at start)
//  clear_w/h      in   X_W+1/Y_W+1  rectangle size (sampled at start)
//  vram_we        out  1        write request
//  vram_ready     in   1        write accepted when vram_we&vram_ready
//  vram_addr      out  ADDR_W   write address
//  vram_data      out  8        write data (= latched clear_char)
//  prog_valid     in   1        stream beat valid
//  prog_ready     out  1        stream beat accepted when valid&ready
//  prog_cmd       in   osd_cmd_t  command
//  prog_last      in   1        final beat of stream
//  be_load_we     out  1        write prog_cmd into enqueuer slot
//  be_load_addr   out  CMD_AW   slot index
//  be_load_data   out  osd_cmd_t  = prog_cmd
//  be_seq_count   out  CNT_W    cmds in chunk (valid S_START..S_WAIT)
//  be_start       out  1        one-cycle chunk start pulse
//  be_busy        in   1        enqueuer busy (status only)
//  be_done        in   1        enqueuer finished chunk (pulse)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; err NONE; counters 0.
//  States: IDLE->CLEAR|LOAD->START->WAIT->(LOAD|DONE); any busy state->ERR.
//  IDLE: init_start=1 latches rect/char, clears cnt/chunk_count/err; ->CLEAR if
//   clear_enable and clipped w,h>0, else ->LOAD.
//  CLEAR: rect clipped to COLS/ROWS (x0>=COLS or y0>=ROWS => empty). Raster order,
//   x fastest; vram_we=1 every cycle; advance only on vram_ready; addr =
//   VRAM_BASE + y*COLS + x mod 2^ADDR_W. After last accepted write ->LOAD.
//  LOAD: prog_ready = (cnt<NUM_CMDS_MAX); accept same cycle: be_load_we=1,
//   be_load_addr=cnt, cnt++, last_seen<=prog_last. After accept, ->START if
//   prog_last or cnt+1==NUM_CMDS_MAX. Zero-latency, 1 beat/cycle throughput.
//  START: be_start=1 one cycle, be_seq_count=cnt latched; chunk_count++; ->WAIT.
//  WAIT: be_seq_count held; wd counts. be_done: last_seen ? ->DONE : cnt<=0, ->LOAD.
//   wd reaching WD_CYCLES (nonzero) before be_done -> ERR, err=TIMEOUT.
//  be_done outside WAIT ignored. be_done and timeout same cycle: be_done wins.
//  init_abort (CLEAR/LOAD/START/WAIT) -> ERR next cycle, err=ABORT; all strobes
//   0 from that cycle; a beat presented that cycle is not accepted (prog_ready=0).
//  DONE/ERR: init_done or init_err held; ->IDLE only when init_start=0.
//  init_busy = state not in {IDLE,DONE,ERR}. Strobes are combinational of state.
//  Async rst mid-run: immediate return to reset values; no partial pulse.
// STRUCTURE
//  osd_cmd_pkg: add osd_init_err_t {ERR_NONE,ERR_ABORT,ERR_TIMEOUT}.
//  state_t local to module. Sub-module osd_rect_addr_gen: clip + x/y raster
//  counters with ready-gated advance, emits addr/last; reusable for OSD windows.
// TESTING
//  full clear 40x20, vram_ready=1 -> 800 writes, addr 0..799, then prog_ready=1.
//  rect x0=38,y0=18,w=5,h=5 -> clipped 2x2: addrs 758,759,798,799.
//  vram_ready toggling 1/0 -> same 800 addrs, no dup/skip, 1600 cycles.
//  150 beats, last on 150, NUM_CMDS_MAX=64 -> chunks 64,64,22; chunk_count=3; done.
//  exactly 64 beats, last on 64 -> one START, seq_count=64, DONE after be_done.
//  be_done withheld, WD_CYCLES=100 -> err=TIMEOUT at cycle 100; abort in LOAD -> ERR.

Source files
------------

// File: rtl/osd_init_seq_chunked_pkg.sv
// Shared types for the OSD bring-up sequencer: command beat, error code, rectangle clip helper.
package osd_init_seq_chunked_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } osd_cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ABORT   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } osd_init_err_t;

  // Length of [origin, origin+len) that lies inside [0, limit).
  function automatic int clip_len(input int origin, input int len, input int limit);
    if (origin >= limit) return 0;
    if (len > limit - origin) return limit - origin;
    return len;
  endfunction

endpackage

// File: rtl/osd_init_seq_chunked_if.sv
// Command stream from the boot/host source into the sequencer (valid/ready with last marker).
interface osd_init_seq_chunked_if;
  import osd_init_seq_chunked_pkg::*;

  logic     prog_valid;
  logic     prog_ready;
  osd_cmd_t prog_cmd;
  logic     prog_last;

  modport master (output prog_valid, output prog_cmd, output prog_last, input prog_ready);
  modport slave  (input prog_valid, input prog_cmd, input prog_last, output prog_ready);
endinterface

// File: rtl/osd_init_seq_chunked_addr_gen.sv
// Clipped rectangle raster walker (x fastest); advances only when the consumer accepts.
module osd_rect_addr_gen
  import osd_init_seq_chunked_pkg::*;
#(
  parameter int COLS      = 40,
  parameter int ROWS      = 20,
  parameter int ADDR_W    = 16,
  parameter int VRAM_BASE = 0,
  parameter int X_W       = $clog2(COLS),
  parameter int Y_W       = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [X_W-1:0]    x0_i,
  input  logic [Y_W-1:0]    y0_i,
  input  logic [X_W:0]      w_i,
  input  logic [Y_W:0]      h_i,
  input  logic              advance_i,
  output logic              empty_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  int w_clip;
  int h_clip;

  logic [X_W-1:0] x0_q, x_last_q, x_q;
  logic [Y_W-1:0] y_last_q, y_q;

  always_comb begin
    w_clip = clip_len(int'(x0_i), int'(w_i), COLS);
    h_clip = clip_len(int'(y0_i), int'(h_i), ROWS);
  end

  assign empty_o = (w_clip == 0) || (h_clip == 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (load_i) begin
      x0_q     <= x0_i;
      x_q      <= x0_i;
      y_q      <= y0_i;
      x_last_q <= X_W'(int'(x0_i) + w_clip - 1);
      y_last_q <= Y_W'(int'(y0_i) + h_clip - 1);
    end else if (advance_i) begin
      if (x_q == x_last_q) begin
        x_q <= x0_q;
        y_q <= y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // Truncation gives the modulo-2^ADDR_W wrap.
  assign addr_o = ADDR_W'(VRAM_BASE + COLS * int'(y_q) + int'(x_q));
  assign last_o = (x_q == x_last_q) && (y_q == y_last_q);

endmodule

// File: rtl/osd_init_seq_chunked.sv
// OSD bring-up sequencer: optional VRAM rectangle fill, then chunked command load into the enqueuer.
// state | meaning: IDLE wait start, CLEAR fill VRAM, LOAD take beats, START kick chunk,
//   WAIT enqueuer running (watchdog), DONE finished OK, ERR aborted or timed out.
module osd_init_seq_chunked
  import osd_init_seq_chunked_pkg::*;
#(
  parameter int COLS         = 40,
  parameter int ROWS         = 20,
  parameter int NUM_CMDS_MAX = 64,
  parameter int ADDR_W       = 16,
  parameter int VRAM_BASE    = 0,
  parameter int WD_CYCLES    = 65535,
  parameter int X_W          = $clog2(COLS),
  parameter int Y_W          = $clog2(ROWS),
  parameter int CMD_AW       = (NUM_CMDS_MAX > 1) ? $clog2(NUM_CMDS_MAX) : 1,
  parameter int CNT_W        = $clog2(NUM_CMDS_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_start_i,
  input  logic                   init_abort_i,
  output logic                   init_busy_o,
  output logic                   init_done_o,
  output osd_init_err_t          init_err_o,
  output logic [7:0]             chunk_count_o,
  input  logic                   clear_enable_i,
  input  logic [7:0]             clear_char_i,
  input  logic [X_W-1:0]         clear_x0_i,
  input  logic [Y_W-1:0]         clear_y0_i,
  input  logic [X_W:0]           clear_w_i,
  input  logic [Y_W:0]           clear_h_i,
  output logic                   vram_we_o,
  input  logic                   vram_ready_i,
  output logic [ADDR_W-1:0]      vram_addr_o,
  output logic [7:0]             vram_data_o,
  osd_init_seq_chunked_if.slave  prog,
  output logic                   be_load_we_o,
  output logic [CMD_AW-1:0]      be_load_addr_o,
  output osd_cmd_t               be_load_data_o,
  output logic [CNT_W-1:0]       be_seq_count_o,
  output logic                   be_start_o,
  input  logic                   be_busy_i,
  input  logic                   be_done_i
);

  localparam int WD_W = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       chunk_q, chunk_d;
  logic             last_seen_q, last_seen_d;
  osd_init_err_t    err_q, err_d;
  logic [7:0]       char_q, char_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic busy, abort, accept, vram_adv, rect_load, rect_empty, rect_last;
  logic unused_be_busy;

  assign unused_be_busy = be_busy_i;

  assign busy      = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                     (state_q == S_START) || (state_q == S_WAIT);
  assign abort     = busy && init_abort_i;
  assign rect_load = (state_q == S_IDLE) && init_start_i;

  // Abort silences every strobe in the cycle it is seen.
  assign vram_we_o       = (state_q == S_CLEAR) && !abort;
  assign vram_adv        = vram_we_o && vram_ready_i;
  assign prog.prog_ready = (state_q == S_LOAD) && (cnt_q < CNT_W'(NUM_CMDS_MAX)) && !abort;
  assign accept          = prog.prog_valid && prog.prog_ready;
  assign be_load_we_o    = accept;
  assign be_load_addr_o  = accept ? cnt_q[CMD_AW-1:0] : '0;
  assign be_load_data_o  = accept ? prog.prog_cmd : '0;
  assign be_start_o      = (state_q == S_START) && !abort;
  assign be_seq_count_o  = ((state_q == S_START) || (state_q == S_WAIT)) ? cnt_q : '0;

  assign init_busy_o   = busy;
  assign init_done_o   = (state_q == S_DONE);
  assign init_err_o    = err_q;
  assign chunk_count_o = chunk_q;
  assign vram_data_o   = char_q;

  osd_rect_addr_gen #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .ADDR_W    (ADDR_W),
    .VRAM_BASE (VRAM_BASE),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) u_rect (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rect_load),
    .x0_i      (clear_x0_i),
    .y0_i      (clear_y0_i),
    .w_i       (clear_w_i),
    .h_i       (clear_h_i),
    .advance_i (vram_adv),
    .empty_o   (rect_empty),
    .addr_o    (vram_addr_o),
    .last_o    (rect_last)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chunk_d     = chunk_q;
    last_seen_d = last_seen_q;
    err_d       = err_q;
    char_d      = char_q;
    wd_d        = wd_q;
    if (abort) begin
      state_d = S_ERR;
      err_d   = ERR_ABORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init_start_i) begin
            char_d      = clear_char_i;
            cnt_d       = '0;
            chunk_d     = '0;
            err_d       = ERR_NONE;
            last_seen_d = 1'b0;
            state_d     = (clear_enable_i && !rect_empty) ? S_CLEAR : S_LOAD;
          end
        end
        S_CLEAR: begin
          if (vram_adv && rect_last) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (accept) begin
            cnt_d       = cnt_q + CNT_W'(1);
            last_seen_d = prog.prog_last;
            if (prog.prog_last || (cnt_q == CNT_W'(NUM_CMDS_MAX - 1))) state_d = S_START;
          end
        end
        S_START: begin
          if (chunk_q != 8'hFF) chunk_d = chunk_q + 8'd1;
          wd_d    = WD_W'(WD_CYCLES - 1);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // Down-counter terminal count; a coincident be_done takes priority.
          if (be_done_i) begin
            if (last_seen_q) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = '0;
              state_d = S_LOAD;
            end
          end else if ((WD_CYCLES != 0) && (wd_q == '0)) begin
            state_d = S_ERR;
            err_d   = ERR_TIMEOUT;
          end else if (wd_q != '0) begin
            wd_d = wd_q - WD_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          if (!init_start_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      chunk_q     <= '0;
      last_seen_q <= 1'b0;
      err_q       <= ERR_NONE;
      char_q      <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chunk_q     <= chunk_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
      char_q      <= char_d;
      wd_q        <= wd_d;
    end
  end

endmodule

// File: tb/tb_osd_init_seq_chunked.sv
// Directed bench for the OSD bring-up sequencer: fills, clipping, backpressure, chunking, watchdog, abort.
module tb_osd_init_seq_chunked;
  import osd_init_seq_chunked_pkg::*;

  localparam int COLS         = 40;
  localparam int ROWS         = 20;
  localparam int NUM_CMDS_MAX = 64;
  localparam int ADDR_W       = 16;
  localparam int WD_CYCLES    = 100;
  localparam int X_W          = 6;
  localparam int Y_W          = 5;
  localparam int CMD_AW       = 6;
  localparam int CNT_W        = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_start, init_abort, init_busy, init_done;
  osd_init_err_t     init_err;
  logic [7:0]        chunk_count;
  logic              clear_enable;
  logic [7:0]        clear_char;
  logic [X_W-1:0]    clear_x0;
  logic [Y_W-1:0]    clear_y0;
  logic [X_W:0]      clear_w;
  logic [Y_W:0]      clear_h;
  logic              vram_we, vram_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic              be_load_we;
  logic [CMD_AW-1:0] be_load_addr;
  osd_cmd_t          be_load_data;
  logic [CNT_W-1:0]  be_seq_count;
  logic              be_start, be_busy, be_done;

  int checks = 0;
  int errors = 0;
  int got_q[$];

  osd_init_seq_chunked_if prog_if();

  osd_init_seq_chunked #(
    .COLS(COLS), .ROWS(ROWS), .NUM_CMDS_MAX(NUM_CMDS_MAX), .ADDR_W(ADDR_W),
    .VRAM_BASE(0), .WD_CYCLES(WD_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .init_start_i(init_start), .init_abort_i(init_abort),
    .init_busy_o(init_busy), .init_done_o(init_done), .init_err_o(init_err),
    .chunk_count_o(chunk_count),
    .clear_enable_i(clear_enable), .clear_char_i(clear_char),
    .clear_x0_i(clear_x0), .clear_y0_i(clear_y0), .clear_w_i(clear_w), .clear_h_i(clear_h),
    .vram_we_o(vram_we), .vram_ready_i(vram_ready), .vram_addr_o(vram_addr), .vram_data_o(vram_data),
    .prog(prog_if),
    .be_load_we_o(be_load_we), .be_load_addr_o(be_load_addr), .be_load_data_o(be_load_data),
    .be_seq_count_o(be_seq_count), .be_start_o(be_start),
    .be_busy_i(be_busy), .be_done_i(be_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic osd_cmd_t cmd_of(input int i);
    osd_cmd_t c;
    c.opcode  = 8'(i + 1);
    c.operand = 24'(i * 7);
    return c;
  endfunction

  task automatic run_clear(input int x0, input int y0, input int w, input int h,
                           input bit toggle, input int exp_cycles);
    int exp_q[$];
    int cyc;
    got_q.delete();
    for (int y = y0; y < y0 + h && y < ROWS; y++)
      for (int x = x0; x < x0 + w && x < COLS; x++)
        exp_q.push_back(y * COLS + x);
    clear_x0 = X_W'(x0); clear_y0 = Y_W'(y0);
    clear_w = 7'(w); clear_h = 6'(h);
    clear_char = 8'h2E; clear_enable = 1'b1; init_start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (cyc < 4000) begin
      vram_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (!vram_we) break;
      if (vram_ready) got_q.push_back(int'(vram_addr));
      if (cyc == 0) chk("vram_data", 32'(vram_data), 32'h2E);
      cyc++;
      @(posedge clk); #1;
    end
    chk("clear_cycles", 32'(cyc), 32'(exp_cycles));
    chk("clear_writes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("clear_addr", 32'(got_q[i]), 32'(exp_q[i]));
    chk("ready_after_clear", 32'(prog_if.prog_ready), 32'd1);
  endtask

  task automatic abort_exit();
    prog_if.prog_valid = 1'b1; prog_if.prog_cmd = cmd_of(99); prog_if.prog_last = 1'b0;
    init_abort = 1'b1;
    #1;
    chk("abort_ready", 32'(prog_if.prog_ready), 32'd0);
    chk("abort_load_we", 32'(be_load_we), 32'd0);
    @(posedge clk); #1;
    chk("abort_err", 32'(init_err), 32'(ERR_ABORT));
    chk("abort_busy", 32'(init_busy), 32'd0);
    init_abort = 1'b0; prog_if.prog_valid = 1'b0; init_start = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_busy", 32'(init_busy), 32'd0);
  endtask

  task automatic run_stream(input int n, input int exp_chunks);
    int b, chunk_i, wait_left, cyc, sz;
    osd_cmd_t c;
    clear_enable = 1'b0; init_start = 1'b1; prog_if.prog_valid = 1'b0; be_done = 1'b0;
    @(posedge clk); #1;
    b = 0; chunk_i = 0; wait_left = 0; cyc = 0; sz = 0;
    while (cyc < 3000) begin
      c = cmd_of(b);
      prog_if.prog_valid = (b < n);
      prog_if.prog_cmd   = c;
      prog_if.prog_last  = (b == n - 1);
      be_done            = (wait_left == 1);
      #1;
      if (init_done) break;
      if (prog_if.prog_valid && prog_if.prog_ready) begin
        chk("load_we", 32'(be_load_we), 32'd1);
        chk("load_addr", 32'(be_load_addr), 32'(b % NUM_CMDS_MAX));
        chk("load_data", 32'(be_load_data), 32'(c));
        b++;
      end
      if (be_start) begin
        sz = n - NUM_CMDS_MAX * chunk_i;
        if (sz > NUM_CMDS_MAX) sz = NUM_CMDS_MAX;
        chk("seq_count", 32'(be_seq_count), 32'(sz));
        chunk_i++;
        wait_left = 4;
      end else if (wait_left > 0) begin
        if (wait_left == 1) chk("seq_count_held", 32'(be_seq_count), 32'(sz));
        wait_left--;
      end
      cyc++;
      @(posedge clk); #1;
    end
    be_done = 1'b0; prog_if.prog_valid = 1'b0; prog_if.prog_last = 1'b0;
    chk("stream_done", 32'(init_done), 32'd1);
    chk("stream_err", 32'(init_err), 32'(ERR_NONE));
    chk("stream_beats", 32'(b), 32'(n));
    chk("stream_starts", 32'(chunk_i), 32'(exp_chunks));
    chk("chunk_count", 32'(chunk_count), 32'(exp_chunks));
    init_start = 1'b0;
    @(posedge clk); #1;
    chk("stream_idle_busy", 32'(init_busy), 32'd0);
    chk("stream_idle_done", 32'(init_done), 32'd0);
  endtask

  task automatic run_wait(input int done_at, input bit exp_done);
    int k;
    clear_enable = 1'b0; init_start = 1'b1; be_done = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      prog_if.prog_valid = 1'b1; prog_if.prog_cmd = cmd_of(i); prog_if.prog_last = (i == 2);
      #1;
      chk("wd_ready", 32'(prog_if.prog_ready), 32'd1);
      @(posedge clk); #1;
    end
    prog_if.prog_valid = 1'b0; prog_if.prog_last = 1'b0;
    #1;
    chk("wd_start", 32'(be_start), 32'd1);
    chk("wd_seq_count", 32'(be_seq_count), 32'd3);
    k = 0;
    while (k < 300) begin
      @(posedge clk); #1;
      k++;
      be_done = (k == done_at);
      #1;
      if (init_done || init_err != ERR_NONE) break;
    end
    be_done = 1'b0;
    chk("wd_cycles", 32'(k), 32'd101);
    chk("wd_done", 32'(init_done), 32'(exp_done));
    chk("wd_err", 32'(init_err), exp_done ? 32'(ERR_NONE) : 32'(ERR_TIMEOUT));
    init_start = 1'b0;
    @(posedge clk); #1;
    chk("wd_idle_busy", 32'(init_busy), 32'd0);
  endtask

  initial begin
    init_start = 1'b0; init_abort = 1'b0; clear_enable = 1'b0; clear_char = '0;
    clear_x0 = '0; clear_y0 = '0; clear_w = '0; clear_h = '0;
    vram_ready = 1'b0; be_busy = 1'b0; be_done = 1'b0;
    prog_if.prog_valid = 1'b0; prog_if.prog_cmd = '0; prog_if.prog_last = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(init_busy), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(init_err), 32'(ERR_NONE));
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    chk("rst_prog_ready", 32'(prog_if.prog_ready), 32'd0);
    chk("rst_be_start", 32'(be_start), 32'd0);
    chk("rst_chunk_count", 32'(chunk_count), 32'd0);
    chk("rst_seq_count", 32'(be_seq_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(init_busy), 32'd0);

    run_clear(0, 0, 40, 20, 1'b0, 800);
    abort_exit();

    run_clear(38, 18, 5, 5, 1'b0, 4);
    chk("clip_addr0", 32'(got_q.size() > 0 ? got_q[0] : -1), 32'd758);
    chk("clip_addr3", 32'(got_q.size() > 3 ? got_q[3] : -1), 32'd799);
    abort_exit();

    run_clear(0, 0, 40, 20, 1'b1, 1600);
    abort_exit();

    clear_x0 = 6'd45; clear_y0 = '0; clear_w = 7'd5; clear_h = 6'd5;
    clear_enable = 1'b1; init_start = 1'b1;
    @(posedge clk); #1;
    chk("empty_rect_we", 32'(vram_we), 32'd0);
    chk("empty_rect_ready", 32'(prog_if.prog_ready), 32'd1);
    abort_exit();

    run_stream(150, 3);
    run_stream(64, 1);

    run_wait(0, 1'b0);
    run_wait(100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
